// File: rtl/pl_fetch_pc.sv
// Fetch-stage program counter: sequential fetch, EX redirects (branch/call/return) and a return-address stack.
// Define PL_FETCH_BREAKPOINT_EN to add the PC breakpoint / HALT state and its ports.
module pl_fetch_pc #(
    parameter int unsigned PROG_CTR_WID = 10,
    parameter int unsigned STACK_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    br_req,
    input  logic [2:0]              br_cond_sel,
    input  logic [PROG_CTR_WID-1:0] br_target,
    input  logic                    call_req,
    input  logic                    ret_req,
    input  logic [PROG_CTR_WID-1:0] link_addr,
    input  logic [3:0]              branch_conds_MEMWB,
`ifdef PL_FETCH_BREAKPOINT_EN
    input  logic [PROG_CTR_WID-1:0] bp_addr,
    input  logic                    bp_enable,
    input  logic                    bp_resume,
    output logic                    bp_halted,
`endif
    output logic [PROG_CTR_WID-1:0] imem_addr,
    output logic                    imem_rd_en,
    output logic                    fetch_valid,
    output logic                    flush,
    output logic                    stack_overflow,
    output logic                    stack_underflow
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0]        PTR_FULL = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]        PTR_ONE  = PTR_W'(1);
    localparam logic [PROG_CTR_WID-1:0] PC_ONE   = PROG_CTR_WID'(1);

`ifdef PL_FETCH_BREAKPOINT_EN
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_REDIRECT = 2'd2, S_HALT = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_REDIRECT = 2'd2} state_e;
`endif

    state_e                  state_q, state_d;
    logic [PROG_CTR_WID-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PROG_CTR_WID-1:0] ras_q [STACK_DEPTH];
    logic                    ovf_q, ovf_d, unf_q, unf_d;
    logic                    rd_en_q, rd_en_d, fetch_valid_q, fetch_valid_d, flush_q, flush_d;
    logic                    push_c, redirect_c, br_taken_c;
`ifdef PL_FETCH_BREAKPOINT_EN
    logic                    halted_q, halted_d, bp_skip_q, bp_skip_d;
`endif

    // Branch condition decode against the MEM/WB flags
    always_comb begin
        br_taken_c = 1'b0;
        case (br_cond_sel)
            3'd0:    br_taken_c = 1'b1;
            3'd1:    br_taken_c = branch_conds_MEMWB[0];
            3'd2:    br_taken_c = branch_conds_MEMWB[1];
            3'd3:    br_taken_c = branch_conds_MEMWB[2];
            3'd4:    br_taken_c = branch_conds_MEMWB[3];
            3'd5:    br_taken_c = ~branch_conds_MEMWB[0];
            3'd6:    br_taken_c = ~branch_conds_MEMWB[3];
            default: br_taken_c = 1'b0;
        endcase
    end

    // State, PC and RAS registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            pc_q          <= '0;
            ptr_q         <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            rd_en_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
`ifdef PL_FETCH_BREAKPOINT_EN
            halted_q      <= 1'b0;
            bp_skip_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ptr_q         <= ptr_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            rd_en_q       <= rd_en_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            if (push_c) begin
                ras_q[IDX_W'(ptr_q)] <= link_addr;
            end
`ifdef PL_FETCH_BREAKPOINT_EN
            halted_q      <= halted_d;
            bp_skip_q     <= bp_skip_d;
`endif
        end
    end

    // Next-state / next-PC: ret > call > taken branch > stall > increment
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push_c     = 1'b0;
        redirect_c = 1'b0;
`ifdef PL_FETCH_BREAKPOINT_EN
        bp_skip_d  = bp_skip_q;
`endif
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_REDIRECT: begin
                if (ret_req) begin
                    redirect_c = 1'b1;
                    if (ptr_q == '0) begin
                        pc_d  = '0;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = ras_q[IDX_W'(ptr_q - PTR_ONE)];
                        ptr_d = ptr_q - PTR_ONE;
                    end
                end else if (call_req) begin
                    redirect_c = 1'b1;
                    pc_d       = br_target;
                    if (ptr_q == PTR_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                        ptr_d  = ptr_q + PTR_ONE;
                    end
                end else if (br_req && br_taken_c) begin
                    redirect_c = 1'b1;
                    pc_d       = br_target;
                end else if (!(stall && state_q == S_RUN)) begin
                    pc_d = pc_q + PC_ONE;
                end
                state_d = redirect_c ? S_REDIRECT : S_RUN;
            end
`ifdef PL_FETCH_BREAKPOINT_EN
            S_HALT: begin
                if (bp_resume) begin
                    state_d   = S_RUN;
                    bp_skip_d = 1'b1;
                end
            end
`endif
            default: state_d = S_BOOT;
        endcase
`ifdef PL_FETCH_BREAKPOINT_EN
        // Breakpoint is suppressed only while the resumed PC has not yet advanced
        if (state_q != S_HALT) begin
            if (pc_d != pc_q) bp_skip_d = 1'b0;
            if (bp_enable && pc_d == bp_addr && !(bp_skip_q && pc_d == pc_q)) begin
                state_d = S_HALT;
            end
        end
`endif
    end

    // Registered outputs decoded from the next state
    always_comb begin
        rd_en_d       = 1'b0;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
`ifdef PL_FETCH_BREAKPOINT_EN
        halted_d      = 1'b0;
`endif
        case (state_d)
            S_RUN: begin
                rd_en_d       = 1'b1;
                fetch_valid_d = 1'b1;
            end
            S_REDIRECT: begin
                rd_en_d = 1'b1;
                flush_d = 1'b1;
            end
`ifdef PL_FETCH_BREAKPOINT_EN
            S_HALT: begin
                halted_d = 1'b1;
                flush_d  = redirect_c;
            end
`endif
            default: ;
        endcase
    end

    assign imem_addr       = pc_q;
    assign imem_rd_en      = rd_en_q;
    assign fetch_valid     = fetch_valid_q;
    assign flush           = flush_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
`ifdef PL_FETCH_BREAKPOINT_EN
    assign bp_halted       = halted_q;
`endif

endmodule

// File: tb/tb_pl_fetch_pc.sv
// Self-checking bench for pl_fetch_pc: vector table through a scoreboard queue plus reset/breakpoint sequences.
module tb_pl_fetch_pc;
    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall, br_req, call_req, ret_req;
    logic [2:0]   br_cond_sel;
    logic [W-1:0] br_target, link_addr;
    logic [3:0]   branch_conds_MEMWB;
    logic [W-1:0] imem_addr;
    logic         imem_rd_en, fetch_valid, flush, stack_overflow, stack_underflow;
`ifdef PL_FETCH_BREAKPOINT_EN
    logic [W-1:0] bp_addr;
    logic         bp_enable, bp_resume, bp_halted;
`endif

    pl_fetch_pc #(.PROG_CTR_WID(W), .STACK_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_req(br_req), .br_cond_sel(br_cond_sel),
        .br_target(br_target), .call_req(call_req), .ret_req(ret_req), .link_addr(link_addr),
        .branch_conds_MEMWB(branch_conds_MEMWB),
`ifdef PL_FETCH_BREAKPOINT_EN
        .bp_addr(bp_addr), .bp_enable(bp_enable), .bp_resume(bp_resume), .bp_halted(bp_halted),
`endif
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .fetch_valid(fetch_valid), .flush(flush),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         stall;
        logic         br;
        logic [2:0]   sel;
        logic [3:0]   conds;
        logic [W-1:0] tgt;
        logic         call_r;
        logic         ret_r;
        logic [W-1:0] link;
    } in_t;

    typedef struct packed {
        logic [W-1:0] addr;
        logic         rd;
        logic         fv;
        logic         fl;
        logic         ovf;
        logic         unf;
        logic         halt;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    out_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic in_t in_idle();
        in_t r = '0;
        return r;
    endfunction

    function automatic in_t in_stall();
        in_t r = '0;
        r.stall = 1'b1;
        return r;
    endfunction

    function automatic in_t in_br(input logic [2:0] sel, input logic [3:0] c, input logic [W-1:0] t);
        in_t r = '0;
        r.br = 1'b1; r.sel = sel; r.conds = c; r.tgt = t;
        return r;
    endfunction

    function automatic in_t in_call(input logic [W-1:0] t, input logic [W-1:0] l);
        in_t r = '0;
        r.call_r = 1'b1; r.tgt = t; r.link = l;
        return r;
    endfunction

    function automatic in_t in_ret();
        in_t r = '0;
        r.ret_r = 1'b1;
        return r;
    endfunction

    function automatic out_t o_run(input logic [W-1:0] a, input logic ov, input logic un);
        out_t r = '0;
        r.addr = a; r.rd = 1'b1; r.fv = 1'b1; r.ovf = ov; r.unf = un;
        return r;
    endfunction

    function automatic out_t o_rdr(input logic [W-1:0] a, input logic ov, input logic un);
        out_t r = '0;
        r.addr = a; r.rd = 1'b1; r.fl = 1'b1; r.ovf = ov; r.unf = un;
        return r;
    endfunction

    function automatic out_t o_zero();
        out_t r = '0;
        return r;
    endfunction

    function automatic vec_t mk(input in_t i, input out_t e);
        vec_t v;
        v.in = i; v.exp = e;
        return v;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.addr = imem_addr; a.rd = imem_rd_en; a.fv = fetch_valid; a.fl = flush;
        a.ovf = stack_overflow; a.unf = stack_underflow;
`ifdef PL_FETCH_BREAKPOINT_EN
        a.halt = bp_halted;
`else
        a.halt = 1'b0;
`endif
        return a;
    endfunction

    task automatic drive(input in_t i);
        stall = i.stall; br_req = i.br; br_cond_sel = i.sel; branch_conds_MEMWB = i.conds;
        br_target = i.tgt; call_req = i.call_r; ret_req = i.ret_r; link_addr = i.link;
    endtask

    task automatic check_now(input string nm);
        out_t a, e;
        a = sample();
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected entry queued", nm);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got addr=%h rd=%b fv=%b fl=%b ovf=%b unf=%b halt=%b, want addr=%h rd=%b fv=%b fl=%b ovf=%b unf=%b halt=%b",
                         nm, a.addr, a.rd, a.fv, a.fl, a.ovf, a.unf, a.halt,
                         e.addr, e.rd, e.fv, e.fl, e.ovf, e.unf, e.halt);
            end
        end
    endtask

    task automatic expect_now(input out_t e, input string nm);
        exp_q.push_back(e);
        check_now(nm);
    endtask

    task automatic step(input in_t i, input out_t e, input string nm);
        drive(i);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_now(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[$];
        in_t  both;
        out_t halted_o;

        reset = 1'b0;
        drive(in_idle());
`ifdef PL_FETCH_BREAKPOINT_EN
        bp_addr = '0; bp_enable = 1'b0; bp_resume = 1'b0;
`endif

        // Sequential fetch, conditional branches, back-to-back redirects, stall, wrap
        for (int k = 0; k < 4; k++) tbl.push_back(mk(in_idle(), o_run(W'(k), 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd1, 4'b0001, 10'h120), o_rdr(10'h120, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h121, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd1, 4'b0000, 10'h120), o_run(10'h122, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd2, 4'b0010, 10'h050), o_rdr(10'h050, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h051, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd7, 4'b1111, 10'h300), o_run(10'h052, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd5, 4'b0000, 10'h060), o_rdr(10'h060, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd4, 4'b1000, 10'h070), o_rdr(10'h070, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h071, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd6, 4'b1000, 10'h090), o_run(10'h072, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd3, 4'b0100, 10'h0A0), o_rdr(10'h0A0, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd2, 4'b1101, 10'h0B0), o_run(10'h0A1, 1'b0, 1'b0)));
        tbl.push_back(mk(in_br(3'd0, 4'b0000, 10'h1FF), o_rdr(10'h1FF, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h200, 1'b0, 1'b0)));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(in_stall(), o_run(10'h200, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h201, 1'b0, 1'b0)));
        both = in_br(3'd0, 4'b0000, 10'h3FE);
        both.stall = 1'b1;
        tbl.push_back(mk(both,                           o_rdr(10'h3FE, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h3FF, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h000, 1'b0, 1'b0)));
        tbl.push_back(mk(in_idle(),                      o_run(10'h001, 1'b0, 1'b0)));
        // Nine nested calls into an eight-deep RAS, then nine returns
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(in_call(W'(10'h100 + k), W'(10'h010 + k)), o_rdr(W'(10'h100 + k), k == 8, 1'b0)));
        tbl.push_back(mk(in_idle(), o_run(10'h109, 1'b1, 1'b0)));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(in_ret(), o_rdr(W'(10'h017 - k), 1'b1, 1'b0)));
        tbl.push_back(mk(in_ret(),  o_rdr(10'h000, 1'b1, 1'b1)));
        tbl.push_back(mk(in_idle(), o_run(10'h001, 1'b1, 1'b1)));
        // Simultaneous call and return: return wins and nothing is pushed
        tbl.push_back(mk(in_call(10'h200, 10'h055), o_rdr(10'h200, 1'b1, 1'b1)));
        tbl.push_back(mk(in_idle(),                 o_run(10'h201, 1'b1, 1'b1)));
        both = in_call(10'h300, 10'h077);
        both.ret_r = 1'b1;
        tbl.push_back(mk(both,      o_rdr(10'h055, 1'b1, 1'b1)));
        tbl.push_back(mk(in_idle(), o_run(10'h056, 1'b1, 1'b1)));
        tbl.push_back(mk(in_ret(),  o_rdr(10'h000, 1'b1, 1'b1)));
        tbl.push_back(mk(in_idle(), o_run(10'h001, 1'b1, 1'b1)));

        repeat (3) @(posedge clk);
        #1;
        expect_now(o_zero(), "reset_hold");
        reset = 1'b1;
        expect_now(o_zero(), "boot_cycle");

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].in, tbl[k].exp, $sformatf("vec%0d", k));
        end

        // Reset asserted while in REDIRECT clears everything, including the RAS
        step(in_call(10'h150, 10'h0AB), o_rdr(10'h150, 1'b1, 1'b1), "pre_reset_call");
        reset = 1'b0;
        #1;
        expect_now(o_zero(), "reset_async");
        @(posedge clk);
        #1;
        expect_now(o_zero(), "reset_held");
        reset = 1'b1;
        expect_now(o_zero(), "boot_after_reset");
        step(in_idle(), o_run(10'h000, 1'b0, 1'b0), "post_reset_run");
        step(in_ret(),  o_rdr(10'h000, 1'b0, 1'b1), "post_reset_ras_empty");
        step(in_idle(), o_run(10'h001, 1'b0, 1'b1), "post_reset_next");

`ifdef PL_FETCH_BREAKPOINT_EN
        reset = 1'b0;
        @(posedge clk);
        #1;
        bp_addr = 10'h004;
        bp_enable = 1'b1;
        reset = 1'b1;
        expect_now(o_zero(), "bp_boot");
        for (int k = 0; k < 4; k++) step(in_idle(), o_run(W'(k), 1'b0, 1'b0), $sformatf("bp_run%0d", k));
        halted_o = o_zero();
        halted_o.addr = 10'h004;
        halted_o.halt = 1'b1;
        step(in_idle(), halted_o, "bp_halt");
        step(in_br(3'd0, 4'b0000, 10'h3C0), halted_o, "bp_halt_ignores_branch");
        bp_resume = 1'b1;
        step(in_idle(), o_run(10'h004, 1'b0, 1'b0), "bp_resume");
        bp_resume = 1'b0;
        step(in_idle(), o_run(10'h005, 1'b0, 1'b0), "bp_after_resume");
        bp_enable = 1'b0;
`else
        halted_o = o_zero();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
